// File: rtl/rv_mc_boot_loader.sv
// Byte-stream program loader for rv_mc: assembles little-endian words,
// writes them to the unified RAM, then releases the core from reset.
module rv_mc_boot_loader #(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic              run_q;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              take;
    logic [31:0]       word_in;

    // asm_q holds the first three bytes; the fourth completes the word
    assign word_in   = {in_data, asm_q};
    assign in_ready  = run_q && (state_q == S_LEN || state_q == S_DATA);
    assign take      = in_valid && in_ready;
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == S_DONE);
    assign cpu_rst   = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LEN;
            run_q   <= 1'b0;
            cnt_q   <= '0;
            asm_q   <= '0;
            word_q  <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            word_q  <= word_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        word_d  = word_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_LEN: begin
                if (take) begin
                    cnt_d = cnt_q + 2'd1;
                    asm_d = {in_data, asm_q[23:8]};
                    if (cnt_q == 2'd3) begin
                        if (word_in == 32'd0) begin
                            state_d = S_DONE;
                        end else if (word_in > 32'(MEM_WORDS)) begin
                            state_d = S_ERR;
                        end else begin
                            // L==MEM_WORDS truncates to 0 and wraps to the top index
                            last_d  = word_in[ADDR_W-1:0] - ADDR_W'(1);
                            word_d  = '0;
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    cnt_d = cnt_q + 2'd1;
                    asm_d = {in_data, asm_q[23:8]};
                    if (cnt_q == 2'd3) begin
                        addr_d  = word_q;
                        wdata_d = word_in;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (word_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    word_d  = word_q + ADDR_W'(1);
                    state_d = S_DATA;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_LEN;
        endcase
    end

endmodule
